// File: rtl/pq_pkg.sv
// Shared types for the sorted-register priority queue.
//   KEY_WIDTH / VAL_WIDTH : field widths of one queue entry
//   kv_t                  : packed entry, key in the MSBs
//   state_t               : control FSM states
package pq_pkg;

    localparam int unsigned KEY_WIDTH = 8;
    localparam int unsigned VAL_WIDTH = 8;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_t;

endpackage

// File: rtl/sr_pq_cell.sv
// One slot of the sorted priority-queue array.
//   clk, rst_n            : clock, async active-low reset
//   i_load                : take the captured new entry
//   i_shl                 : take the entry of the slot nearer the tail (i+1)
//   i_shr                 : take the entry of the slot nearer the head (i-1)
//   i_new                 : captured new entry
//   i_hi_valid/i_hi_kv    : slot i+1 contents
//   i_lo_valid/i_lo_kv    : slot i-1 contents
//   o_valid/o_kv          : registered slot contents
//   o_lt_c                : new key strictly less than this slot's key
module sr_pq_cell
    import pq_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_load,
    input  logic                           i_shl,
    input  logic                           i_shr,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] i_new,
    input  logic                           i_hi_valid,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] i_hi_kv,
    input  logic                           i_lo_valid,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] i_lo_kv,
    output logic                           o_valid,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] o_kv,
    output logic                           o_lt_c
);

    localparam int unsigned W = KEY_WIDTH + VAL_WIDTH;

    logic         r_valid;
    logic [W-1:0] r_kv;
    logic         w_nxt_valid;
    logic [W-1:0] w_nxt_kv;

    // Strict compare keeps equal keys ahead of the new entry (FIFO tie-break).
    assign o_lt_c = i_new[W-1 -: KEY_WIDTH] < r_kv[W-1 -: KEY_WIDTH];

    // Slot source select.
    always_comb begin
        w_nxt_valid = r_valid;
        w_nxt_kv    = r_kv;
        if (i_load) begin
            w_nxt_valid = 1'b1;
            w_nxt_kv    = i_new;
        end else if (i_shl) begin
            w_nxt_valid = i_hi_valid;
            w_nxt_kv    = i_hi_kv;
        end else if (i_shr) begin
            w_nxt_valid = i_lo_valid;
            w_nxt_kv    = i_lo_kv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_kv    <= '0;
        end else begin
            r_valid <= w_nxt_valid;
            r_kv    <= w_nxt_kv;
        end
    end

    assign o_valid = r_valid;
    assign o_kv    = r_kv;

endmodule

// File: rtl/sr_pq.sv
// Sorted shift-register priority queue, min key first, FIFO among equal keys.
//   clk, rst_n : clock, async active-low reset
//   enq, deq   : requests, sampled only when not busy
//   kvi        : entry to enqueue
//   kvo        : registered head entry (zero when empty)
//   busy       : high during the single UPDATE cycle
//   full/empty : registered occupancy flags
module sr_pq
    import pq_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enq,
    input  logic                           deq,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] kvo,
    output logic                           busy,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned W  = KEY_WIDTH + VAL_WIDTH;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    state_t        r_state;
    logic          r_busy, r_full, r_empty, r_enq, r_deq;
    kv_t           r_new;
    logic [W-1:0]  r_kvo;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;

    logic [DEPTH:0]   w_valid;
    logic [W-1:0]     w_kv [0:DEPTH];
    logic [DEPTH-1:0] w_lt;
    logic [DEPTH:0]   w_after;
    logic [DEPTH-1:0] w_at_p;
    logic [DEPTH-1:0] w_load, w_shl, w_shr;
    logic             w_do_enq, w_do_deq, w_do_rep;
    logic             w_head_valid;
    logic [W-1:0]     w_head_kv;

    // Virtual empty slot past the tail feeds the last cell on a shift-left.
    assign w_valid[DEPTH] = 1'b0;
    assign w_kv[DEPTH]    = '0;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        logic         w_lo_valid;
        logic [W-1:0] w_lo_kv;
        if (g == 0) begin : g_head
            assign w_lo_valid = 1'b0;
            assign w_lo_kv    = '0;
        end else begin : g_body
            assign w_lo_valid = w_valid[g-1];
            assign w_lo_kv    = w_kv[g-1];
        end
        sr_pq_cell u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_load     (w_load[g]),
            .i_shl      (w_shl[g]),
            .i_shr      (w_shr[g]),
            .i_new      (r_new),
            .i_hi_valid (w_valid[g+1]),
            .i_hi_kv    (w_kv[g+1]),
            .i_lo_valid (w_lo_valid),
            .i_lo_kv    (w_lo_kv),
            .o_valid    (w_valid[g]),
            .o_kv       (w_kv[g]),
            .o_lt_c     (w_lt[g])
        );
    end

    // w_after[i]: slot i lies at or behind the sorted insert point p.
    always_comb begin
        w_after[DEPTH] = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_after[i] = !w_valid[i] || w_lt[i];
        end
        w_at_p[0] = w_after[0];
        for (int unsigned i = 1; i < DEPTH; i++) begin
            w_at_p[i] = w_after[i] && !w_after[i-1];
        end
    end

    assign w_do_enq = r_busy && r_enq && !r_deq && !r_full;
    assign w_do_deq = r_busy && r_deq && !r_enq && !r_empty;
    assign w_do_rep = r_busy && r_enq && r_deq && !r_empty && !w_lt[0];

    // Per-slot shift/load select; replace drops the head then inserts at p-1.
    always_comb begin
        w_load = '0;
        w_shl  = '0;
        w_shr  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_do_enq) begin
                w_load[i] = w_at_p[i];
                w_shr[i]  = w_after[i] && !w_at_p[i];
            end else if (w_do_deq) begin
                w_shl[i]  = 1'b1;
            end else if (w_do_rep) begin
                w_shl[i]  = !w_after[i+1];
                w_load[i] = w_after[i+1] && !w_after[i];
            end
        end
    end

    // Next head entry so kvo lands on the same edge as the array.
    always_comb begin
        w_head_valid = w_valid[0];
        w_head_kv    = w_kv[0];
        if (w_load[0]) begin
            w_head_valid = 1'b1;
            w_head_kv    = r_new;
        end else if (w_shl[0]) begin
            w_head_valid = w_valid[1];
            w_head_kv    = w_kv[1];
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_enq) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_do_deq) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Control FSM: capture in IDLE, commit in UPDATE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_enq   <= 1'b0;
            r_deq   <= 1'b0;
            r_new   <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_kvo   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enq || deq) begin
                        r_enq   <= enq;
                        r_deq   <= deq;
                        r_new   <= kv_t'(kvi);
                        r_state <= ST_UPDATE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_count <= w_count_nxt;
                    r_full  <= (w_count_nxt == CW'(DEPTH));
                    r_empty <= (w_count_nxt == '0);
                    r_kvo   <= w_head_valid ? w_head_kv : '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign kvo   = r_kvo;
    assign busy  = r_busy;
    assign full  = r_full;
    assign empty = r_empty;

endmodule

// File: tb/tb_sr_pq.sv
// Directed bench for sr_pq with a reference queue model and expectation scoreboard.
module tb_sr_pq;
    import pq_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned W     = KEY_WIDTH + VAL_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enq = 1'b0;
    logic         deq = 1'b0;
    logic [W-1:0] kvi = '0;
    logic [W-1:0] kvo;
    logic         busy, full, empty;

    sr_pq #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .enq   (enq),
        .deq   (deq),
        .kvi   (kvi),
        .kvo   (kvo),
        .busy  (busy),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] kvo;
        logic         empty;
        logic         full;
        int           count;
    } exp_t;

    kv_t  mq[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: sorted queue, new entry placed after equal keys.
    task automatic model_insert(input kv_t x);
        int idx = mq.size();
        for (int j = 0; j < mq.size(); j++) begin
            if (mq[j].key > x.key) begin
                idx = j;
                break;
            end
        end
        mq.insert(idx, x);
    endtask

    task automatic model_apply(input logic e, input logic d, input kv_t x);
        exp_t ex;
        if (e && !d) begin
            if (mq.size() < DEPTH) model_insert(x);
        end else if (d && !e) begin
            if (mq.size() > 0) void'(mq.pop_front());
        end else if (e && d) begin
            if (mq.size() > 0 && !(x.key < mq[0].key)) begin
                void'(mq.pop_front());
                model_insert(x);
            end
        end
        ex.kvo   = (mq.size() > 0) ? W'(mq[0]) : '0;
        ex.empty = (mq.size() == 0);
        ex.full  = (mq.size() == DEPTH);
        ex.count = mq.size();
        sb.push_back(ex);
    endtask

    // One request; optionally keeps enq high with another entry during UPDATE.
    task automatic op(input string tag, input logic e, input logic d,
                      input logic [7:0] k, input logic [7:0] v, input logic hold);
        exp_t ex;
        kv_t  x;
        x.key = k;
        x.val = v;
        enq = e;
        deq = d;
        kvi = W'(x);
        model_apply(e, d, x);
        @(posedge clk);
        #1;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        if (hold) begin
            enq = 1'b1;
            deq = 1'b0;
            kvi = {8'd2, 8'd0};
        end else begin
            enq = 1'b0;
            deq = 1'b0;
        end
        @(posedge clk);
        #1;
        enq = 1'b0;
        deq = 1'b0;
        ex = sb.pop_front();
        chk({tag, ".kvo"},   32'(kvo),         32'(ex.kvo));
        chk({tag, ".empty"}, 32'(empty),       32'(ex.empty));
        chk({tag, ".full"},  32'(full),        32'(ex.full));
        chk({tag, ".count"}, 32'(dut.r_count), 32'(ex.count));
        chk({tag, ".idle"},  32'(busy),        32'd0);
    endtask

    initial begin
        // Reset and idle state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.full",  32'(full),  32'd0);
        chk("rst.busy",  32'(busy),  32'd0);
        chk("rst.kvo",   32'(kvo),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle.busy", 32'(busy), 32'd0);
        chk("idle.kvo",  32'(kvo),  32'd0);

        // Basic ordering
        op("b.enq8",  1, 0, 8'd8,  8'd14, 0);
        op("b.enq11", 1, 0, 8'd11, 8'd11, 0);
        op("b.enq9",  1, 0, 8'd9,  8'd9,  0);
        chk("b.head", 32'(kvo), 32'h080E);
        op("b.deq",   0, 1, 8'd0,  8'd0,  0);
        chk("b.head2", 32'(kvo), 32'h0909);
        op("b.drain1", 0, 1, 8'd0, 8'd0, 0);
        op("b.drain2", 0, 1, 8'd0, 8'd0, 0);

        // FIFO tie-break on equal keys
        op("t.enq0", 1, 0, 8'd7, 8'd0, 0);
        op("t.enq1", 1, 0, 8'd7, 8'd1, 0);
        op("t.enq2", 1, 0, 8'd7, 8'd2, 0);
        chk("t.first", 32'(kvo), 32'h0700);
        op("t.deq0", 0, 1, 8'd0, 8'd0, 0);
        op("t.deq1", 0, 1, 8'd0, 8'd0, 0);
        op("t.deq2", 0, 1, 8'd0, 8'd0, 0);
        op("t.deqE", 0, 1, 8'd0, 8'd0, 0);

        // Fill, overflow, replace while full, then drain to see the tail
        for (int k = 8; k >= 1; k--) op("f.fill", 1, 0, 8'(k), 8'(k), 0);
        op("f.ovf", 1, 0, 8'd0, 8'd0, 0);
        chk("f.ovf.key", 32'(kvo[W-1 -: KEY_WIDTH]), 32'd1);
        op("f.rep12", 1, 1, 8'd12, 8'd12, 0);
        chk("f.rep.key", 32'(kvo[W-1 -: KEY_WIDTH]), 32'd2);
        for (int k = 0; k < DEPTH; k++) op("f.drain", 0, 1, 8'd0, 8'd0, 0);

        // Replace corner cases
        op("r.emptyrep", 1, 1, 8'd5, 8'd5, 0);
        op("r.enq4",     1, 0, 8'd4, 8'd4, 0);
        op("r.rep1",     1, 1, 8'd1, 8'd1, 0);
        op("r.rep4",     1, 1, 8'd4, 8'd9, 0);
        op("r.rep6",     1, 1, 8'd6, 8'd6, 0);
        op("r.drain",    0, 1, 8'd0, 8'd0, 0);

        // Request held during busy is dropped
        op("x.hold", 1, 0, 8'd5, 8'd5, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("x.kvo",   32'(kvo),         32'h0505);
        chk("x.count", 32'(dut.r_count), 32'd1);

        // Reset in the middle of UPDATE
        enq = 1'b1;
        kvi = {8'd3, 8'd3};
        @(posedge clk);
        #1;
        enq = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("a.empty", 32'(empty),       32'd1);
        chk("a.busy",  32'(busy),        32'd0);
        chk("a.kvo",   32'(kvo),         32'd0);
        chk("a.count", 32'(dut.r_count), 32'd0);
        mq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        op("a.enq", 1, 0, 8'd6, 8'd1, 0);
        chk("sb.left", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
